// File: rtl/relu_layer_seq.sv
// Layer sequencer for the ReLU activation stage: streams accumulator words through
// the registered ReLU stage into the activation buffer and counts clipped negatives.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_READ  | one accumulator read per cycle, index 0..N-1
// S_DRAIN | last two words finishing the ReLU stage and the write
// S_DONE  | one-cycle completion pulse
module relu_layer_seq #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 7
) (
   input  logic              clkext,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   num_neurons,
   input  logic              last_layer,
   output logic              acc_rd_en,
   output logic [ADDR_W-1:0] acc_rd_addr,
   input  logic [DATA_W-1:0] acc_rd_data,
   output logic [DATA_W-1:0] relu_data_in,
   output logic              relu_en,
   output logic              relu_bypass,
   input  logic [DATA_W-1:0] relu_out,
   output logic              act_wr_en,
   output logic [ADDR_W-1:0] act_wr_addr,
   output logic [DATA_W-1:0] act_wr_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   clip_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] N_MAX = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] N_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W:0]     n_q;
   logic                last_q;
   logic [ADDR_W-1:0]   rd_cnt;
   logic                drain_cnt;
   logic                v1, v2;
   logic [ADDR_W-1:0]   a1, a2;
   logic [ADDR_W:0]     clip_q;
   logic [ADDR_W:0]     n_clamp;
   logic                rd_last;
   logic                start_ok;

   assign n_clamp  = (num_neurons > N_MAX) ? N_MAX : num_neurons;
   assign rd_last  = ({1'b0, rd_cnt} == (n_q - N_ONE));
   assign start_ok = start && !abort && (state_q == S_IDLE);

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (start) state_d = (n_clamp == '0) ? S_DONE : S_READ;
            S_READ:  if (rd_last) state_d = S_DRAIN;
            S_DRAIN: if (drain_cnt == 1'b0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clkext or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         n_q       <= '0;
         last_q    <= 1'b0;
         rd_cnt    <= '0;
         drain_cnt <= 1'b0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         a1        <= '0;
         a2        <= '0;
         clip_q    <= '0;
      end else begin
         state_q <= state_d;
         if (start_ok) begin
            n_q    <= n_clamp;
            last_q <= last_layer;
            rd_cnt <= '0;
         end else if (state_q == S_READ && !rd_last) begin
            rd_cnt <= rd_cnt + 1'b1;
         end
         // two-cycle drain timer, loaded while reading and expiring at zero
         if (state_q == S_READ)
            drain_cnt <= 1'b1;
         else if (state_q == S_DRAIN)
            drain_cnt <= drain_cnt - 1'b1;
         if (abort) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
         end else begin
            v1 <= acc_rd_en;
            v2 <= v1;
         end
         a1 <= acc_rd_addr;
         a2 <= a1;
         if (start_ok)
            clip_q <= '0;
         else if (v1 && acc_rd_data[DATA_W-1] && !last_q && !abort)
            clip_q <= clip_q + N_ONE;
      end
   end

   assign acc_rd_en    = (state_q == S_READ);
   assign acc_rd_addr  = rd_cnt;
   assign busy         = (state_q == S_READ) || (state_q == S_DRAIN);
   assign done         = (state_q == S_DONE) && !abort;
   assign relu_en      = v1;
   assign relu_data_in = v1 ? acc_rd_data : '0;
   assign relu_bypass  = busy ? last_q : 1'b0;
   // the abort cycle already suppresses the write that was in flight
   assign act_wr_en    = v2 && !abort;
   assign act_wr_addr  = a2;
   assign act_wr_data  = act_wr_en ? relu_out : '0;
   assign clip_cnt     = clip_q;

endmodule

// File: doc/relu_layer_seq.md
# relu_layer_seq

Layer-level sequencer for the ReLU activation stage of the MNIST NPU. After a layer's MAC pass, it streams N 16-bit accumulator words from the accumulator buffer through the single registered ReLU stage and writes the results to the activation buffer. It owns the ReLU stage's enable and bypass controls: bypass is set for the final (logit) layer. It also reports a per-layer count of clipped negative values for debug.

## Interface
- DATA_W, 16, accumulator and activation word width (two's complement)
- ADDR_W, 7, buffer address width; the maximum layer size is 2^ADDR_W neurons
- CLKEXT  in  1  single system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  one-cycle pulse that launches a layer pass; ignored unless the block is in IDLE
- ABORT  in  1  synchronous kill; takes priority over everything except RST
- NUM_NEURONS  in  ADDR_W+1  layer size; latched on an accepted START
- LAST_LAYER  in  1  latched on START; 1 means bypass ReLU for the whole pass
- ACC_RD_EN  out  1  accumulator buffer read strobe
- ACC_RD_ADDR  out  ADDR_W  accumulator read address
- ACC_RD_DATA  in  DATA_W  read data, valid exactly 1 cycle after ACC_RD_EN
- RELU_DATA_IN  out  DATA_W  operand to the ReLU stage
- RELU_EN  out  1  ReLU stage enable; when 0, the stage registers zero
- RELU_BYPASS  out  1  ReLU bypass
- RELU_OUT  in  DATA_W  registered ReLU result; 1 cycle after RELU_DATA_IN
- ACT_WR_EN  out  1  activation buffer write strobe
- ACT_WR_ADDR  out  ADDR_W  write address
- ACT_WR_DATA  out  DATA_W  write data (equal to RELU_OUT)
- BUSY  out  1  high from START acceptance until the last write completes
- DONE  out  1  one-cycle pulse when the pass is complete
- CLIP_CNT  out  ADDR_W+1  number of words zeroed in the last pass; stable from DONE until the next START

## Operation
- States:
  - IDLE → READ on START with NUM_NEURONS > 0.
  - IDLE → DONE on START with NUM_NEURONS == 0.
  - READ → DRAIN after the read of index N-1 is issued.
  - DRAIN → DONE after 2 cycles.
  - DONE → IDLE after 1 cycle.
- NUM_NEURONS values above 2^ADDR_W are clamped to 2^ADDR_W at latch time.
- READ: ACC_RD_EN = 1 and ACC_RD_ADDR = rd_cnt each cycle, with rd_cnt running 0..N-1 and no gaps.
- Pipeline stage 1 is a valid bit and address delayed 1 cycle from the read:
  - RELU_DATA_IN = ACC_RD_DATA.
  - RELU_EN = v1.
  - RELU_BYPASS = the latched LAST_LAYER value while BUSY, otherwise 0.
- Pipeline stage 2 is the valid bit and address delayed 2 cycles from the read:
  - ACT_WR_EN = v2.
  - ACT_WR_ADDR = stage-2 address.
  - ACT_WR_DATA = RELU_OUT.
- CLIP_CNT is cleared on an accepted START. It increments in stage 1 when v1 = 1, ACC_RD_DATA[DATA_W-1] = 1 and bypass is 0.
- When RELU_EN = 0, RELU_DATA_IN = 0.
- ABORT in any state:
  - Next state is IDLE.
  - v1 and v2 are cleared, so the in-flight writes are suppressed (no ACT_WR_EN after the ABORT cycle).
  - No DONE pulse.
  - CLIP_CNT holds its partial value.
- START asserted while not in IDLE is ignored. It is not queued.
- START and ABORT in the same IDLE cycle: ABORT wins and START is dropped.

## Timing
- Reset values: state IDLE, all strobes 0, all addresses/data 0, BUSY 0, DONE 0, CLIP_CNT 0, latched registers 0.
- START is sampled on edge t0. Cycles t0+k below refer to that edge.
- Reads issue in cycles t0+1 .. t0+N.
- Writes occur in cycles t0+3 .. t0+N+2. Read index i is written in cycle t0+3+i.
- DONE is high in cycle t0+N+3 only.
- BUSY is high in cycles t0+1 .. t0+N+2, then low from DONE onward.
- Throughput is 1 word per cycle. A pass takes N+3 cycles; back-to-back passes need a new START from DONE or later.
- N = 0: no reads or writes, BUSY stays 0, DONE is high in cycle t0+1.
- RST asserted mid-pass: outputs go to reset values immediately (asynchronous). No partial writes occur after RST.

## Test plan
- N = 4, LAST_LAYER = 0, accumulator = {0x0005, 0xFFFB, 0x8000, 0x7FFF} -> writes to addresses 0..3 of {0x0005, 0x0000, 0x0000, 0x7FFF} in cycles t0+3..t0+6, DONE in cycle t0+7, CLIP_CNT = 2.
- Same data with LAST_LAYER = 1 -> writes {0x0005, 0xFFFB, 0x8000, 0x7FFF}, RELU_BYPASS = 1 throughout, CLIP_CNT = 0.
- N = 128, all words 0xFFFF -> 128 consecutive writes of 0x0000 to addresses 0..127, DONE in cycle t0+131, CLIP_CNT = 128. Also N = 200 -> clamped, same result.
- N = 0 -> no ACC_RD_EN and no ACT_WR_EN, DONE in cycle t0+1. START pulses during a 10-word pass are ignored (exactly 10 writes, one DONE).
- ABORT at t0+5 of a 10-word pass -> the last write is address 1 at t0+4, no writes after that, no DONE, state IDLE at t0+6. A new START is then accepted normally.
- RST pulse at t0+4 -> all outputs 0 asynchronously and no further writes. A pass after RST deasserts completes correctly.
